// File: rtl/tx_sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tx_sched_pkg                                               |
// | Purpose  : K-code constants and segment FSM state encoding shared by  |
// |            the TX scheduler and its checksum helper.                  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package tx_sched_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] SEG_START = 8'h5C;
  localparam logic [7:0] SEG_STOP  = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_STOP   = 3'd4,
    ST_CSUM_H = 3'd5,
    ST_CSUM_L = 3'd6
  } seg_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_checksum.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : seg_checksum                                               |
// | Purpose  : 16-bit running byte sum for one segment frame. start loads |
// |            the first byte (the address), byte_valid adds the next.    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module seg_checksum
  import tx_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [15:0] sum
);

  // Load on start, accumulate on every valid payload byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 16'h0000;
    end else if (start) begin
      sum <= {8'h00, byte_in};
    end else if (byte_valid) begin
      sum <= sum + {8'h00, byte_in};
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tx_scheduler                                               |
// | Purpose  : Two-lane transceiver slot scheduler. Event lane carries    |
// |            periodic K28.5 commas and single events; data lane carries |
// |            dbus on even slots and segment frames on odd slots.        |
// | Options  : TX_SCHED_CHECKSUM_EN adds CSUM_H/CSUM_L after STOP.        |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int COMMA_PERIOD = 4,
  parameter int SEG_BYTES    = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   link_ready,
  input  logic [7:0]             dbus,
  input  logic                   ev_valid,
  output logic                   ev_ready,
  input  logic [7:0]             ev_code,
  input  logic                   seg_valid,
  output logic                   seg_ready,
  input  logic [7:0]             seg_addr,
  input  logic [SEG_BYTES*8-1:0] seg_data,
  output logic [15:0]            tx_data,
  output logic [1:0]             tx_is_k,
  output logic                   busy
);

  localparam int CNT_W = (SEG_BYTES > 1) ? $clog2(SEG_BYTES) : 1;

  logic [1:0]             rst_sync;
  logic                   rst_n;
  logic [7:0]             phase;
  logic                   odd;
  seg_state_t             state;
  seg_state_t             state_next;
  logic [7:0]             addr_q;
  logic [SEG_BYTES*8-1:0] shift_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   seg_hs;
  logic                   data_slot;
  logic [7:0]             ev_byte;
  logic                   ev_k;
  logic [7:0]             data_byte;
  logic                   data_k;

  // Reset asserts immediately, releases two clock edges after aresetn rises
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Slot phase and parity; both restart from zero whenever the link drops
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 8'd0;
      odd   <= 1'b0;
    end else if (!link_ready) begin
      phase <= 8'd0;
      odd   <= 1'b0;
    end else begin
      phase <= (phase == 8'(COMMA_PERIOD - 1)) ? 8'd0 : phase + 8'd1;
      odd   <= ~odd;
    end
  end

  // Events never displace a comma, so phase 0 is closed to requests
  assign ev_ready  = rst_n && link_ready && (phase != 8'd0);
  assign seg_ready = rst_n && link_ready && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign seg_hs    = seg_valid && seg_ready;
  assign data_slot = link_ready && odd && (state == ST_DATA);

`ifdef TX_SCHED_CHECKSUM_EN
  logic [15:0] csum_sum;

  seg_checksum u_csum (
    .clk        (aclk),
    .rst_n      (rst_n),
    .start      (seg_hs),
    .byte_valid (data_slot),
    .byte_in    (seg_hs ? seg_addr : shift_q[7:0]),
    .sum        (csum_sum)
  );
`endif

  // Frame state register
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame sequencing and data-lane byte selection; states move on odd slots only
  always_comb begin
    state_next = state;
    data_byte  = odd ? 8'h00 : dbus;
    data_k     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (seg_hs) state_next = ST_START;
      end
      ST_START: begin
        if (odd) begin
          data_byte  = SEG_START;
          data_k     = 1'b1;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (odd) begin
          data_byte  = addr_q;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (odd) begin
          data_byte = shift_q[7:0];
          if (cnt_q == CNT_W'(SEG_BYTES - 1)) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (odd) begin
          data_byte  = SEG_STOP;
          data_k     = 1'b1;
`ifdef TX_SCHED_CHECKSUM_EN
          state_next = ST_CSUM_H;
`else
          state_next = ST_IDLE;
`endif
        end
      end
`ifdef TX_SCHED_CHECKSUM_EN
      ST_CSUM_H: begin
        if (odd) begin
          data_byte  = ~csum_sum[15:8];
          state_next = ST_CSUM_L;
        end
      end
      ST_CSUM_L: begin
        if (odd) begin
          data_byte  = ~csum_sum[7:0];
          state_next = ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
    if (!link_ready) state_next = ST_IDLE;
  end

  // Capture a frame on handshake, then walk the payload LSB-first
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 8'h00;
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (seg_hs) begin
      addr_q  <= seg_addr;
      shift_q <= seg_data;
      cnt_q   <= '0;
    end else if (data_slot) begin
      shift_q <= shift_q >> 8;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Event lane: comma on phase 0, otherwise the event accepted this slot
  always_comb begin
    ev_byte = 8'h00;
    ev_k    = 1'b0;
    if (phase == 8'd0) begin
      ev_byte = K28_5;
      ev_k    = 1'b1;
    end else if (ev_valid && ev_ready) begin
      ev_byte = ev_code;
    end
  end

  // Registered line outputs, silenced while the link is down
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data <= 16'h0000;
      tx_is_k <= 2'b00;
    end else if (!link_ready) begin
      tx_data <= 16'h0000;
      tx_is_k <= 2'b00;
    end else begin
      tx_data <= {data_byte, ev_byte};
      tx_is_k <= {data_k, ev_k};
    end
  end

endmodule
`default_nettype wire

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 SHALL have parameter COMMA_PERIOD, default 4: number of slots between K28.5 commas on the event lane (range 2..255).
REQ-002 SHALL have parameter SEG_BYTES, default 16: payload bytes per segment frame.
REQ-003 SHALL have port aclk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port link_ready, input, 1: transceiver TX reset done.
REQ-006 SHALL have port dbus, input, 8: distributed-bus byte, sampled on even slots.
REQ-007 SHALL have port ev_valid / ev_ready, input / output, 1 / 1: event request handshake.
REQ-008 SHALL have port ev_code, input, 8: event code.
REQ-009 SHALL have port seg_valid / seg_ready, input / output, 1 / 1: segment frame handshake.
REQ-010 SHALL have port seg_addr, input, 8: segment address.
REQ-011 SHALL have port seg_data, input, SEG_BYTES*8: payload, byte 0 in bits [7:0] and sent first.
REQ-012 SHALL have port tx_data, output, 16: [15:8] data lane, [7:0] event lane.
REQ-013 SHALL have port tx_is_k, output, 2: [1] data-lane K flag, [0] event-lane K flag.
REQ-014 SHALL have port busy, output, 1: segment frame in progress.

Function
REQ-015 SHALL register tx_data and tx_is_k; a slot decided at edge N appears after edge N.
REQ-016 SHALL keep slot counter `phase` (0..COMMA_PERIOD-1, wraps) and parity bit `odd`, both advancing every cycle while link_ready=1.
REQ-017 SHALL drive the event lane with 0xBC and is_k[0]=1 when phase==0, then with the accepted ev_code in a non-comma slot, else with 0x00.
REQ-018 SHALL assert ev_ready = link_ready && phase!=0; an event is consumed on the ev_valid&&ev_ready edge and appears in that same slot; there is no event queueing.
REQ-019 SHALL drive the data lane with dbus on even slots and is_k[1]=0.
REQ-020 SHALL drive the data lane on odd slots from the FSM below, else with 0x00.
REQ-021 SHALL implement FSM IDLE->START->ADDR->DATA(SEG_BYTES slots)->STOP->CSUM_H->CSUM_L->IDLE, advancing only on odd slots.
REQ-022 SHALL, in IDLE, assert seg_ready = link_ready; on handshake, latch addr and data and enter START; START emits on the next odd slot.
REQ-023 SHALL emit 0x5C in START and 0x3C in STOP with is_k[1]=1 (position-based, not value-based); ADDR, DATA and CSUM slots carry is_k[1]=0.
REQ-024 SHALL compute checksum = 0xFFFF minus the 16-bit sum of addr and all payload bytes, sent high byte then low byte.
REQ-025 SHALL hold busy=1 in every state except IDLE; seg_ready=0 while busy=1.
REQ-026 SHALL, when link_ready=0, output tx_data=0 and tx_is_k=0, clear phase and odd, force IDLE (abandoning any frame without resume), and deassert both readies.

Reset
REQ-027 SHALL, on aresetn=0, set tx_data=0, tx_is_k=0, busy=0, ev_ready=0, seg_ready=0, phase=0, odd=0, FSM=IDLE; release is synchronised internally with a two-flop deassertion.

Configuration
REQ-028 SHALL, with TX_SCHED_CHECKSUM_EN defined, include CSUM_H/CSUM_L; without it, STOP goes directly to IDLE and no checksum logic is synthesised.

Structure
REQ-029 SHALL place K-code constants (K28_5=0xBC, SEG_START=0x5C, SEG_STOP=0x3C) and the FSM state enum in package tx_sched_pkg.
REQ-030 SHALL implement the checksum accumulator as sub-module seg_checksum (start/byte-valid in, 16-bit sum out).

Verification
REQ-031 SHALL test idle stream: link_ready=1, no requests, COMMA_PERIOD=4 -> event lane BC,00,00,00 repeating, with is_k[0] only on BC.
REQ-032 SHALL test a frame: addr 0x04, payload AD 74 AD 74 7A 34 74 AD repeated twice -> odd slots 5C,04,payload,3C,F7,D9, with is_k[1] only on 5C and 3C (checksum macro on).
REQ-033 SHALL test an event collision: ev_valid held with ev_code 0x7E -> ev_ready low on phase 0; 0x7E emitted in the first non-comma slot; BC never displaced.
REQ-034 SHALL test back-to-back frames: seg_valid held high -> seg_ready pulses once per frame; the next START follows CSUM_L by exactly 2 slots.
REQ-035 SHALL test a mid-frame drop: link_ready deasserted during DATA -> next cycle busy=0 and outputs 0; after re-assert, a new frame starts cleanly from START.
REQ-036 SHALL test the macro off: same frame as REQ-032 -> ends at 3C, and seg_ready returns on the following cycle.
